// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants, types and helpers for the seven-segment scan logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   NUM_DIGITS     - digits per display frame
//   AN_ALL_OFF     - anode pattern with every digit dark (active-low)
//   digit_idx_t    - 2-bit scan index
//   an_onehot_low  - anode pattern that lights exactly one digit
//   nibble_at      - selects the hex nibble for a given digit index
package ssd_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [3:0]  AN_ALL_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Anodes are active-low, so the selected digit is the single zero bit.
  function automatic logic [3:0] an_onehot_low(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

  // Digit 0 is the rightmost nibble [3:0]; digit 3 is [15:12].
  function automatic logic [3:0] nibble_at(input logic [15:0] v, input digit_idx_t idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/ssd_scan4_if.sv
// ssd_scan4_if: bundles the value-load request and the scanned display outputs.
// Latency: n/a (wiring only).
// Backpressure: none; load is a fire-and-forget strobe, outputs are free-running.
//
// Signals:
//   load       - 1-cycle strobe to capture value
//   value      - 16-bit display value, four hex digits
//   blank_en   - 1 = blank leading-zero digits 3..1
//   digit      - nibble of the currently selected digit (to the decoder)
//   an         - active-low anode enables, one-hot-low or all off
//   frame_done - 1-cycle pulse on the 3 -> 0 scan wrap
interface ssd_scan4_if;

  logic        load;
  logic [15:0] value;
  logic        blank_en;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;

  // Producer of display values / consumer of the scan outputs.
  modport master (
    output load,
    output value,
    output blank_en,
    input  digit,
    input  an,
    input  frame_done
  );

  // The scanner itself.
  modport slave (
    input  load,
    input  value,
    input  blank_en,
    output digit,
    output an,
    output frame_done
  );

endinterface

// File: rtl/ssd_tick_gen.sv
// ssd_tick_gen: free-running prescaler producing a 1-cycle tick every REFRESH_DIV clocks.
// Latency: tick is combinational from the counter; first tick REFRESH_DIV-1 cycles after reset.
// Backpressure: none; the counter never stalls.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset (counter to 0)
//   tick - high while the counter sits at its terminal value REFRESH_DIV-1
module ssd_tick_gen #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  // With REFRESH_DIV=1 the terminal value is 0, so the counter parks at 0
  // and tick stays high every cycle.
  assign w_tick = (r_cnt == CNT_LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_scan4.sv
// ssd_scan4: four-digit multiplexed display scanner with tear-free updates and leading-zero blanking.
// Latency: outputs registered; a load becomes visible at the next frame wrap (<= 4*REFRESH_DIV cycles).
// Backpressure: none; loads are never refused, the last load before a wrap wins.
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   bus.load/value    - capture a new 16-bit display value
//   bus.blank_en      - blank leading zero digits 3..1 (sampled every cycle)
//   bus.digit         - nibble for the selected digit, to the hex decoder
//   bus.an            - active-low anode enables
//   bus.frame_done    - pulse on the digit 3 -> digit 0 wrap
module ssd_scan4
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  ssd_scan4_if.slave   bus
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  digit_idx_t  r_idx;
  logic [15:0] r_disp;      // value currently being scanned out
  logic [15:0] r_pend;      // value waiting for the next frame boundary
  logic        r_pend_v;
  logic [3:0]  r_digit;
  logic [3:0]  r_an;
  logic        r_frame_done;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  logic        w_tick;
  logic        w_wrap;
  digit_idx_t  w_idx_next;
  logic [15:0] w_disp_next;
  logic [3:0]  w_blank;     // per-digit blank flags for w_disp_next
  logic [3:0]  w_an_next;
  logic [3:0]  w_digit_next;

  ssd_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_wrap     = w_tick & (r_idx == digit_idx_t'(NUM_DIGITS - 1));
  assign w_idx_next = w_tick ? (r_idx + 2'd1) : r_idx;

  // The displayed value only changes at a frame boundary. A load landing on
  // the wrap cycle itself is taken directly, ahead of anything pending, so it
  // is never delayed by a full extra frame.
  always_comb begin
    w_disp_next = r_disp;
    if (w_wrap) begin
      if (bus.load) begin
        w_disp_next = bus.value;
      end else if (r_pend_v) begin
        w_disp_next = r_pend;
      end
    end
  end

  // Digit k blanks only when it and every more-significant nibble are zero,
  // so interior zeros (e.g. 0x1005) stay lit. Digit 0 is always lit.
  always_comb begin
    logic upper_zero;
    w_blank    = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (w_disp_next[k*4 +: 4] == 4'h0);
      w_blank[k] = bus.blank_en & upper_zero;
    end
  end

  // Outputs are computed from the *next* index and value so that digit and
  // anode move together with idx/disp on the same edge.
  always_comb begin
    w_digit_next = nibble_at(w_disp_next, w_idx_next);
    w_an_next    = an_onehot_low(w_idx_next);
    if (w_blank[w_idx_next]) begin
      w_an_next = AN_ALL_OFF;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_digit      <= 4'h0;
      r_an         <= an_onehot_low(2'd0);
      r_frame_done <= 1'b0;
    end else begin
      r_idx        <= w_idx_next;
      r_disp       <= w_disp_next;
      r_digit      <= w_digit_next;
      r_an         <= w_an_next;
      r_frame_done <= w_wrap;

      // Pending slot: a wrap always consumes it (either by promoting it or by
      // being superseded by a same-cycle load); otherwise the latest load wins.
      if (w_wrap) begin
        r_pend_v <= 1'b0;
      end else if (bus.load) begin
        r_pend   <= bus.value;
        r_pend_v <= 1'b1;
      end
    end
  end

  assign bus.digit      = r_digit;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ssd_scan4.sv
module tb_ssd_scan4;

  logic clk = 1'b0;
  logic rst;
  int   k;          // edges since the last reset edge
  int   checks;
  int   failures;

  always #5 clk = ~clk;

  ssd_scan4_if u_if ();

  ssd_scan4 #(
    .REFRESH_DIV (4),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // Expected anode pattern for a lit digit, written out by hand.
  function automatic logic [3:0] an_exp(input int idx);
    case (idx)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic step_to(input int target);
    while (k < target) step();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] d, input logic [3:0] a, input logic f);
    chk({tag, ".digit"}, {12'h0, u_if.digit}, {12'h0, d});
    chk({tag, ".an"}, {12'h0, u_if.an}, {12'h0, a});
    chk({tag, ".frame_done"}, {15'h0, u_if.frame_done}, {15'h0, f});
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    k           = 0;
    rst         = 1'b1;
    u_if.load     = 1'b0;
    u_if.value    = 16'h0;
    u_if.blank_en = 1'b0;
    step();
    step();
    chk_out("reset", 4'h0, 4'b1110, 1'b0);
    rst = 1'b0;
    k   = 0;

    // First frame with no load: each digit held 4 cycles, wrap on edge 16.
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("scan.an", {12'h0, u_if.an}, {12'h0, an_exp((i / 4) % 4)});
      chk("scan.frame_done", {15'h0, u_if.frame_done}, {15'h0, (i == 16)});
      chk("scan.digit", {12'h0, u_if.digit}, 16'h0);
    end

    // Load 1A2F during digit1; nothing visible until the wrap at edge 32.
    step_to(21);
    u_if.load = 1'b1; u_if.value = 16'h1A2F;
    step();
    u_if.load = 1'b0; u_if.value = 16'h0;
    step_to(28); chk_out("pend_hidden", 4'h0, 4'b0111, 1'b0);
    step_to(32); chk_out("1a2f.d0", 4'hF, 4'b1110, 1'b1);
    step_to(36); chk_out("1a2f.d1", 4'h2, 4'b1101, 1'b0);
    step_to(40); chk_out("1a2f.d2", 4'hA, 4'b1011, 1'b0);
    step_to(44); chk_out("1a2f.d3", 4'h1, 4'b0111, 1'b0);

    // Two loads in one frame: last one wins.
    step_to(45);
    u_if.load = 1'b1; u_if.value = 16'h1111;
    step();
    u_if.value = 16'h2222;
    step();
    u_if.load = 1'b0; u_if.value = 16'h0;
    chk_out("two_loads.before", 4'h1, 4'b0111, 1'b0);
    step_to(48); chk_out("two_loads.d0", 4'h2, 4'b1110, 1'b1);
    step_to(52); chk_out("two_loads.d1", 4'h2, 4'b1101, 1'b0);

    // Pending 7777, then 5555 on the exact wrap cycle: 5555 bypasses and the
    // pending 7777 is dropped (not shown at the following wrap).
    step_to(57);
    u_if.load = 1'b1; u_if.value = 16'h7777;
    step();
    u_if.load = 1'b0; u_if.value = 16'h0;
    step_to(63); chk_out("wrap_load.before", 4'h2, 4'b0111, 1'b0);
    u_if.load = 1'b1; u_if.value = 16'h5555;
    step();
    u_if.load = 1'b0; u_if.value = 16'h0;
    chk_out("wrap_load.d0", 4'h5, 4'b1110, 1'b1);
    step_to(72); chk_out("wrap_load.d2", 4'h5, 4'b1011, 1'b0);
    step_to(80); chk_out("wrap_load.no_stale", 4'h5, 4'b1110, 1'b1);

    // Blanking with 0030: digits 3 and 2 dark, digit1 shows 3, digit0 shows 0.
    u_if.blank_en = 1'b1;
    u_if.load = 1'b1; u_if.value = 16'h0030;
    step();
    u_if.load = 1'b0; u_if.value = 16'h0;
    step_to(95);  chk_out("blank.before", 4'h5, 4'b0111, 1'b0);
    step_to(96);  chk_out("blank30.d0", 4'h0, 4'b1110, 1'b1);
    step_to(100); chk_out("blank30.d1", 4'h3, 4'b1101, 1'b0);
    step_to(104); chk_out("blank30.d2", 4'h0, 4'b1111, 1'b0);
    step_to(108); chk_out("blank30.d3", 4'h0, 4'b1111, 1'b0);
    // blank_en is not latched: dropping it mid-digit relights digit3.
    step_to(109);
    u_if.blank_en = 1'b0;
    step();
    chk_out("blank_off.d3", 4'h0, 4'b0111, 1'b0);
    u_if.blank_en = 1'b1;

    // Value 0000 with blanking: only digit0 lit.
    step_to(111);
    u_if.load = 1'b1; u_if.value = 16'h0000;
    step();
    u_if.load = 1'b0;
    chk_out("blank0.d0", 4'h0, 4'b1110, 1'b1);
    step_to(116); chk_out("blank0.d1", 4'h0, 4'b1111, 1'b0);
    step_to(120); chk_out("blank0.d2", 4'h0, 4'b1111, 1'b0);
    step_to(124); chk_out("blank0.d3", 4'h0, 4'b1111, 1'b0);
    step_to(128); chk_out("blank0.wrap", 4'h0, 4'b1110, 1'b1);

    // Reset mid-frame with a pending load: the pending value is discarded.
    u_if.blank_en = 1'b0;
    step_to(130);
    u_if.load = 1'b1; u_if.value = 16'hABCD;
    step();
    u_if.load = 1'b0; u_if.value = 16'h0;
    step_to(132); chk_out("pre_rst.d1", 4'h0, 4'b1101, 1'b0);
    step_to(133);
    rst = 1'b1;
    step();
    rst = 1'b0;
    k   = 0;
    chk_out("mid_rst", 4'h0, 4'b1110, 1'b0);
    step_to(3);  chk_out("post_rst.hold", 4'h0, 4'b1110, 1'b0);
    step_to(4);  chk_out("post_rst.d1", 4'h0, 4'b1101, 1'b0);
    step_to(16); chk_out("post_rst.wrap", 4'h0, 4'b1110, 1'b1);
    step_to(20); chk_out("post_rst.d1b", 4'h0, 4'b1101, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_scan4.md
Name: ssd_scan4

Overview:
- Four-digit multiplexed-display scanner. It sits directly upstream of the per-digit hex-to-seven-segment decoder.
- Holds a 16-bit display value and time-multiplexes one 4-bit nibble at a time onto `digit`. The decoder consumes `digit`.
- Drives active-low anode enables in step with `digit`.
- Supports optional leading-zero blanking and tear-free value updates; a new value is applied only at a frame boundary.

Parameters:
- REFRESH_DIV, 50000, clk cycles each digit stays selected (≥1); sim benches use 4.
- CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  1-cycle strobe: capture `value` for display.
- value  in  16  hex digits; [3:0]=digit0 (rightmost) … [15:12]=digit3.
- blank_en  in  1  1 = blank leading-zero digits 3..1.
- digit  out  4  nibble for the currently selected digit; feeds the decoder input.
- an  out  4  anode enables, active-low, one-hot-low; an[i]=0 selects digit i.
- frame_done  out  1  1-cycle pulse when scan wraps from digit 3 to digit 0.

Behaviour:
- Reset is synchronous, active-high, on clk: `rst` sampled high sets all of the following, overriding every other input that cycle:
  - cnt=0, idx=0
  - disp=16'h0000, pend=16'h0000, pend_v=0
  - digit=4'h0, an=4'b1110, frame_done=0
- Reset mid-scan or mid-pending update: a pending value is discarded.
- Prescaler:
  - cnt counts 0..REFRESH_DIV-1, then returns to 0.
  - tick is asserted (comb) when cnt==REFRESH_DIV-1.
  - REFRESH_DIV=1 gives tick every cycle.
- Scan index: on tick, idx <= (idx+1) mod 4. wrap = tick & (idx==3).
- Value update:
  - load & !wrap: pend <= value, pend_v <= 1. Multiple loads in one frame: last wins.
  - wrap & load (simultaneous): disp <= value, pend_v <= 0. The same-cycle value bypasses pend.
  - wrap & !load & pend_v: disp <= pend, pend_v <= 0.
  - wrap & !pend_v & !load: disp is unchanged.
- Outputs are registered and update on the same edge as idx/disp, so they always reflect the new idx and new disp together:
  - digit <= disp_next nibble at idx_next.
  - an <= ~(4'b0001 << idx_next), unless that digit is blanked, in which case an <= 4'b1111.
  - frame_done <= wrap.
- Blanking (blank_en=1):
  - digit k (k=3..1) is blanked iff disp_next nibbles k..3 are all zero.
  - digit0 is never blanked, so value 0 shows a single "0".
  - `digit` still carries the nibble (0) while blanked.
  - blank_en=0: no blanking.
  - blank_en is sampled each cycle, no latching.
- Latency:
  - From load to first visible effect: ≤ 4·REFRESH_DIV cycles (next wrap).
  - Each digit is held exactly REFRESH_DIV cycles.
  - One frame = 4·REFRESH_DIV cycles.
- Values: no arithmetic on `value`; nibbles pass through as raw hex (A–F legal).

Decomposition:
- Package ssd_pkg:
  - NUM_DIGITS=4
  - AN_ALL_OFF=4'b1111
  - function/constant for the one-hot-low anode pattern
  - digit index type (2 bits)
- Sub-module ssd_tick_gen: prescaler (params REFRESH_DIV, CNT_W; ports clk, rst, tick). Reused for other refresh-rate timers.
- Scan/update/blank logic stays in ssd_scan4.

Test Plan (REFRESH_DIV=4):
- Reset released, no load → digit=0, an=1110 for 4 cycles; then an=1101, 1011, 0111, each 4 cycles. frame_done pulses once at the 3→0 wrap (cycle 16); disp stays 0.
- load value=16'h1A2F mid-frame (during digit1) → display unchanged until wrap. From the wrap cycle: digit=F/an=1110, 2/1101, A/1011, 1/0111.
- Two loads in one frame (16'h1111 then 16'h2222) → only 2222 appears after wrap; 1111 never shown.
- load 16'h5555 on the exact wrap cycle → digit=5 with an=1110 on the very next edge; pend_v=0 afterwards.
- blank_en=1, value=16'h0030 → digits 3 and 2 give an=1111; digit1 gives an=1101, digit=3; digit0 gives an=1110, digit=0. value=16'h0000 → only digit0 lit with 0.
- rst asserted for 1 cycle mid-frame with pending load → next cycle an=1110, digit=0, frame_done=0; pending value never displayed.
